// File: rtl/data_mem_cam.sv
// Data-side memory: word RAM plus a memory-mapped camera pixel FIFO.
// Loads are combinational, stores and FIFO updates land on the rising edge.
module data_mem_cam #(
  parameter int RAM_WORDS  = 256,
  parameter int FIFO_DEPTH = 16,
  parameter int PIX_W      = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             write_enable,
  input  logic [31:0]      Address,
  input  logic [31:0]      WriteData,
  output logic [31:0]      ReadData,
  input  logic             cam_valid,
  input  logic [PIX_W-1:0] cam_pixel,
  input  logic             cam_frame_start,
  output logic             cam_ready
);
  localparam int AW = $clog2(RAM_WORDS);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(FIFO_DEPTH + 1);

  logic [31:0]      ram_mem  [RAM_WORDS];
  logic [PIX_W-1:0] fifo_mem [FIFO_DEPTH];

  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          ovf_q, ovf_d;
  logic          en_q, en_d;
  logic [15:0]   frame_q, frame_d;

  logic [29:0] word;
  logic        ram_sel, data_sel, stat_sel, ctrl_sel;
  logic        full, empty, push, pop, flush, ctrl_wr;
  logic [4:0]  cnt_sat;
  logic        unused_addr;

  assign word        = Address[31:2];
  assign unused_addr = ^Address[1:0];

  assign ram_sel  = (word >> AW) == 30'd0;
  assign data_sel = word == 30'h400;
  assign stat_sel = word == 30'h401;
  assign ctrl_sel = word == 30'h402;

  assign full      = count_q == CW'(FIFO_DEPTH);
  assign empty     = count_q == '0;
  assign cam_ready = en_q & ~full;
  assign push      = cam_valid & cam_ready;
  assign ctrl_wr   = write_enable & ctrl_sel;
  assign pop       = write_enable & data_sel & ~empty;
  assign flush     = ctrl_wr & WriteData[1];

  // Status count field is only 5 bits wide
  assign cnt_sat = (32'(count_q) > 32'd31) ? 5'h1f : 5'(count_q);

  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    ovf_d    = ovf_q | (cam_valid & en_q & full);
    en_d     = ctrl_wr ? WriteData[0] : en_q;
    frame_d  = frame_q + 16'(cam_frame_start & en_q);
    if (flush) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
      ovf_d    = 1'b0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + PW'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
      case ({push, pop})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
      en_q     <= 1'b0;
      frame_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
      ovf_q    <= ovf_d;
      en_q     <= en_d;
      frame_q  <= frame_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push && !flush) fifo_mem[wr_ptr_q] <= cam_pixel;
  end

  always_ff @(posedge clk) begin
    if (write_enable && ram_sel) ram_mem[word[AW-1:0]] <= WriteData;
  end

  always_comb begin
    ReadData = '0;
    unique case (1'b1)
      ram_sel:  ReadData = ram_mem[word[AW-1:0]];
      data_sel: ReadData = empty ? 32'd0 : 32'(fifo_mem[rd_ptr_q]);
      stat_sel: ReadData = {frame_q, 7'd0, en_q, ovf_q, full, empty, cnt_sat};
      ctrl_sel: ReadData = {31'd0, en_q};
      default:  ReadData = '0;
    endcase
  end

endmodule

// File: tb/tb_data_mem_cam.sv
// Scoreboard bench for data_mem_cam against a queue-based reference model.
module tb_data_mem_cam;
  localparam int DEPTH = 16;
  localparam logic [31:0] DATA = 32'h1000;
  localparam logic [31:0] STAT = 32'h1004;
  localparam logic [31:0] CTRL = 32'h1008;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        write_enable = 1'b0;
  logic [31:0] Address = '0;
  logic [31:0] WriteData = '0;
  logic [31:0] ReadData;
  logic        cam_valid = 1'b0;
  logic [7:0]  cam_pixel = '0;
  logic        cam_frame_start = 1'b0;
  logic        cam_ready;

  data_mem_cam #(.RAM_WORDS(256), .FIFO_DEPTH(DEPTH), .PIX_W(8)) dut (
    .clk(clk), .reset(reset), .write_enable(write_enable),
    .Address(Address), .WriteData(WriteData), .ReadData(ReadData),
    .cam_valid(cam_valid), .cam_pixel(cam_pixel),
    .cam_frame_start(cam_frame_start), .cam_ready(cam_ready)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] rd;
    logic        rdy;
    string       nm;
  } exp_t;

  exp_t sb_q[$];
  exp_t e;
  exp_t t;
  int vectors = 0;
  int miscompares = 0;

  // Reference model state
  logic [31:0] m_ram [int];
  logic [7:0]  m_pix [$];
  bit          m_en, m_ovf;
  int          m_fc;

  bit          rst_s = 1'b1, cv_s = 1'b0, fs_s = 1'b0;
  logic [7:0]  px_s = '0;

  function automatic logic [31:0] m_read(input logic [31:0] a);
    int w = int'(a >> 2);
    int n = m_pix.size();
    if (w < 256) return m_ram.exists(w) ? m_ram[w] : 32'hx;
    if (w == 'h400) return (n > 0) ? {24'd0, m_pix[0]} : 32'd0;
    if (w == 'h401)
      return {m_fc[15:0], 7'd0, m_en, m_ovf, n == DEPTH, n == 0,
              5'((n > 31) ? 31 : n)};
    if (w == 'h402) return {31'd0, m_en};
    return 32'd0;
  endfunction

  task automatic m_reset();
    m_pix.delete();
    m_en = 0;
    m_ovf = 0;
    m_fc = 0;
  endtask

  task automatic m_edge(input logic we, input logic [31:0] a,
                        input logic [31:0] wd);
    int w = int'(a >> 2);
    int n = m_pix.size();
    bit rdy = m_en && n < DEPTH;
    bit do_push = cv_s && rdy;
    bit do_pop = we && w == 'h400 && n > 0;
    bit do_flush = we && w == 'h402 && wd[1];
    if (cv_s && m_en && n == DEPTH) m_ovf = 1;
    if (fs_s && m_en) m_fc = (m_fc + 1) % 65536;
    if (we && w < 256) m_ram[w] = wd;
    if (do_flush) begin
      m_pix.delete();
      m_ovf = 0;
    end else begin
      if (do_pop) void'(m_pix.pop_front());
      if (do_push) m_pix.push_back(px_s);
    end
    if (we && w == 'h402) m_en = wd[0];
  endtask

  task automatic cyc(input logic we, input logic [31:0] a,
                     input logic [31:0] wd, input bit chk, input string nm);
    write_enable = we;
    Address = a;
    WriteData = wd;
    reset = rst_s;
    cam_valid = cv_s;
    cam_pixel = px_s;
    cam_frame_start = fs_s;
    if (rst_s) m_reset();
    if (chk) begin
      t.rd = m_read(a);
      t.rdy = m_en && (m_pix.size() < DEPTH);
      t.nm = nm;
      sb_q.push_back(t);
    end
    @(posedge clk);
    if (!rst_s) m_edge(we, a, wd);
    #1;
  endtask

  task automatic rd(input logic [31:0] a, input string nm);
    cyc(1'b0, a, 32'd0, 1'b1, nm);
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    cyc(1'b1, a, d, 1'b0, "");
  endtask

  always @(negedge clk) begin
    if (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      vectors++;
      if (ReadData !== e.rd) begin
        miscompares++;
        $display("FAIL %s: ReadData=%h expected %h", e.nm, ReadData, e.rd);
      end
      vectors++;
      if (cam_ready !== e.rdy) begin
        miscompares++;
        $display("FAIL %s: cam_ready=%b expected %b", e.nm, cam_ready, e.rdy);
      end
    end
  end

  int k;
  logic we_r;
  logic [31:0] a_r, d_r;

  initial begin
    @(posedge clk);
    #1;
    rst_s = 1;
    rd(STAT, "reset_status");
    rst_s = 0;

    wr(32'h10, 32'hDEADBEEF);
    wr(32'h14, 32'h12345678);
    rd(32'h10, "ram_10");
    rd(32'h13, "ram_13");
    rd(32'h14, "ram_14");
    rd(32'h2000, "unmapped");

    cv_s = 1; px_s = 8'hAA;
    cyc(1'b1, CTRL, 32'd1, 1'b1, "enable_cycle");
    cv_s = 0;
    rd(CTRL, "ctrl_read");
    rd(STAT, "no_push_on_enable");

    for (int i = 1; i <= 5; i++) begin
      cv_s = 1; px_s = 8'(i);
      cyc(1'b0, STAT, 32'd0, 1'b1, "push5");
    end
    cv_s = 0;
    rd(STAT, "count5");
    for (int i = 0; i < 5; i++) begin
      rd(DATA, "fifo_order");
      wr(DATA, 32'($urandom));
    end
    rd(STAT, "empty");
    wr(DATA, 32'd0);
    rd(STAT, "pop_empty_ignored");
    rd(DATA, "data_empty");

    cv_s = 1;
    for (int i = 0; i < DEPTH; i++) begin
      px_s = 8'($urandom);
      cyc(1'b0, STAT, 32'd0, 1'b1, "fill");
    end
    px_s = 8'h77;
    cyc(1'b0, STAT, 32'd0, 1'b1, "overflow_cycle");
    cv_s = 0;
    rd(STAT, "full_overflow");
    cv_s = 1; px_s = 8'h66;
    cyc(1'b1, DATA, 32'd0, 1'b1, "pop_push_full");
    cv_s = 0;
    rd(STAT, "count15");

    wr(CTRL, 32'd3);
    rd(STAT, "flushed");
    cv_s = 1;
    for (int i = 0; i < 3; i++) begin
      px_s = 8'(8'h30 + i);
      cyc(1'b0, STAT, 32'd0, 1'b0, "");
    end
    px_s = 8'h33;
    cyc(1'b1, DATA, 32'd0, 1'b1, "push_pop_3");
    cv_s = 0;
    rd(STAT, "count3");
    rd(DATA, "head_advanced");
    cv_s = 1; px_s = 8'h44;
    cyc(1'b1, CTRL, 32'd3, 1'b1, "flush_push");
    cv_s = 0;
    rd(STAT, "flush_wins");

    wr(CTRL, 32'd0);
    fs_s = 1;
    repeat (4) cyc(1'b0, STAT, 32'd0, 1'b0, "");
    fs_s = 0;
    rd(STAT, "frame_disabled");
    wr(CTRL, 32'd1);
    fs_s = 1;
    repeat (65535) cyc(1'b0, STAT, 32'd0, 1'b0, "");
    fs_s = 0;
    rd(STAT, "frame_ffff");
    fs_s = 1;
    cyc(1'b0, STAT, 32'd0, 1'b0, "");
    fs_s = 0;
    rd(STAT, "frame_wrap");

    wr(CTRL, 32'd3);
    cv_s = 1;
    for (int i = 0; i < 7; i++) begin
      px_s = 8'($urandom);
      cyc(1'b0, STAT, 32'd0, 1'b0, "");
    end
    cv_s = 0;
    rd(STAT, "count7");
    rst_s = 1;
    cyc(1'b0, STAT, 32'd0, 1'b1, "async_reset");
    rst_s = 0;
    rd(32'h10, "ram_kept");
    rd(STAT, "post_reset");

    wr(CTRL, 32'd1);
    for (int i = 0; i < 16; i++) wr(32'(i * 4), $urandom);
    repeat (800) begin
      k = $urandom_range(0, 9);
      d_r = $urandom;
      we_r = ($urandom_range(0, 2) == 0);
      case (k)
        0, 1, 2: a_r = 32'($urandom_range(0, 63));
        3, 4:    a_r = DATA;
        5, 6:    a_r = STAT;
        7: begin
          a_r = CTRL;
          d_r[0] = ($urandom_range(0, 7) != 0);
          d_r[1] = ($urandom_range(0, 7) == 0);
        end
        8:       a_r = 32'h400;
        default: a_r = 32'h100C;
      endcase
      cv_s = ($urandom_range(0, 9) < 6);
      px_s = 8'($urandom);
      fs_s = ($urandom_range(0, 15) == 0);
      cyc(we_r, a_r, d_r, 1'b1, "random");
    end
    cv_s = 0;
    fs_s = 0;
    cyc(1'b0, 32'h0, 32'd0, 1'b0, "");

    repeat (2) @(negedge clk);
    if (sb_q.size() != 0) begin
      miscompares++;
      $display("FAIL drain: %0d pending expected 0", sb_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
